// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - command sequencer and result register stage around an 8-bit ALU
//
// Purpose: accepts one ALU operation per cmd handshake, registers the operands
// and select that drive the external combinational ALU, captures the ALU result
// one cycle later and presents it with carry/zero flags on the res port. An
// 8-bit accumulator can be written with the result and fed back as operand A.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op/cmd_a/cmd_b       ALU select and operands
//   cmd_a_acc                take operand A from the accumulator
//   cmd_acc_we               write the result into the accumulator
//   alu_a/alu_b/alu_sel      registered ALU inputs
//   alu_out/alu_cout         ALU result and carry/borrow
//   res_valid/res_ready      result handshake
//   res_data/res_carry/res_zero  registered result and flags
//   acc                      accumulator value
//   op_count                 completed result handshakes (wrapping)
module alu_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_a_acc,
  input  logic             cmd_acc_we,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic [7:0]       acc,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       r_state;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [2:0]       r_alu_sel;
  logic             r_acc_we;
  logic [7:0]       r_res_data;
  logic             r_res_carry;
  logic             r_res_zero;
  logic [7:0]       r_acc;
  logic [CNT_W-1:0] r_op_count;

  logic w_accept;
  logic w_res_done;
  logic w_carry_trusted;

  assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
  assign w_res_done = (r_state == ST_HOLD) && res_ready;

  // The ALU carry is only meaningful for add (000) and sub (001).
  assign w_carry_trusted = (r_alu_sel[2:1] == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_alu_a     <= 8'd0;
      r_alu_b     <= 8'd0;
      r_alu_sel   <= 3'd0;
      r_acc_we    <= 1'b0;
      r_res_data  <= 8'd0;
      r_res_carry <= 1'b0;
      r_res_zero  <= 1'b1;
      r_acc       <= 8'd0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_a   <= cmd_a_acc ? r_acc : cmd_a;
            r_alu_b   <= cmd_b;
            r_alu_sel <= cmd_op;
            r_acc_we  <= cmd_acc_we;
            r_state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res_data  <= alu_out;
          r_res_carry <= w_carry_trusted ? alu_cout : 1'b0;
          r_res_zero  <= (alu_out == 8'd0);
          if (r_acc_we) begin
            r_acc <= alu_out;
          end
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (w_res_done) begin
            r_op_count <= r_op_count + 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign res_valid = (r_state == ST_HOLD);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign res_zero  = r_res_zero;
  assign acc       = r_acc;
  assign op_count  = r_op_count;

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Command sequencer and result register stage wrapped around the combinational 8-bit ALU. It accepts one operation per valid/ready handshake and registers the operands and select that drive the ALU. It captures the ALU result and carry one cycle later, keeps an 8-bit accumulator that can feed back as operand A, and presents the registered result with carry/zero flags on a valid/ready output port.

## Interface
Parameters:
- `CNT_W`, 16: width of the completed-operation counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: sequencer can accept a command.
- `cmd_op`, in, 3: ALU select (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul low byte, 110 A>>1, 111 A<<1).
- `cmd_a`, in, 8: immediate operand A.
- `cmd_b`, in, 8: operand B.
- `cmd_a_acc`, in, 1: when 1, operand A = accumulator; `cmd_a` is ignored.
- `cmd_acc_we`, in, 1: when 1, the result is written to the accumulator.
- `alu_a`, out, 8: registered operand A to the ALU.
- `alu_b`, out, 8: registered operand B to the ALU.
- `alu_sel`, out, 3: registered ALU select.
- `alu_out`, in, 8: ALU result.
- `alu_cout`, in, 1: ALU carry/borrow.
- `res_valid`, out, 1: result present.
- `res_ready`, in, 1: consumer accepts the result.
- `res_data`, out, 8: registered result.
- `res_carry`, out, 1: registered carry.
- `res_zero`, out, 1: 1 when `res_data` == 0.
- `acc`, out, 8: accumulator value.
- `op_count`, out, CNT_W: number of completed result handshakes.

## Operation
- FSM states: IDLE, EXEC, HOLD. The reset state is IDLE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, register:
    - `alu_a` = `cmd_a_acc` ? `acc` : `cmd_a`.
    - `alu_b` = `cmd_b`.
    - `alu_sel` = `cmd_op`.
  - Also latch `cmd_acc_we` internally, then go to EXEC.
- **EXEC**
  - `cmd_ready`=0.
  - Capture `res_data` = `alu_out`.
  - `res_carry` = `alu_cout` for ops 000/001, and 0 for all other ops. The carry output is not trusted for logic, mul or shift ops.
  - `res_zero` = (`alu_out` == 0).
  - If latched we=1, `acc` = `alu_out`.
  - Go to HOLD.
- **HOLD**
  - `res_valid`=1 and `cmd_ready`=0.
  - Result registers stay stable until `res_ready`.
  - On `res_ready`: increment `op_count` (wraps at 2^CNT_W−1 → 0) and go to IDLE.
- `alu_a`/`alu_b`/`alu_sel` hold their values outside the IDLE accept cycle.
- Arithmetic follows the ALU:
  - Add: 8-bit sum plus carry out.
  - Sub: 8-bit difference plus borrow flag.
  - Mul: low 8 bits only.
  - Shifts are logical with zero fill.
- Reset values:
  - `alu_a`, `alu_b`, `alu_sel`, `res_data`, `res_carry`, `acc`, `op_count` = 0.
  - `res_zero`=1, `res_valid`=0.
  - `cmd_ready`=1 (IDLE). Commands are ignored while `rst`=1.

## Timing
- Command accepted at edge N (`cmd_valid` & `cmd_ready`). ALU inputs are valid after N.
- Result is captured at N+1, and `res_valid`=1 after N+1.
- Minimum issue interval is 3 cycles (accept, EXEC, HOLD with `res_ready`=1).
- `cmd_ready` and `res_valid` are never 1 in the same cycle.
- Back-pressure: HOLD persists indefinitely with all outputs stable.
- An accumulator write takes effect after N+1. A back-to-back command with `cmd_a_acc`=1 therefore sees the updated value.
- Reset mid-operation (EXEC or HOLD):
  - All registers clear immediately (asynchronous).
  - The in-flight op is dropped and not counted.
  - `res_valid` drops with no handshake.
- `cmd_valid` in EXEC or HOLD is not accepted; the command must be held by the source.

## Test plan
- **Add with carry:** op 000, A=200, B=100, we=1 → after 2 cycles `res_data`=44, `res_carry`=1, `res_zero`=0, `acc`=44.
- **Accumulator chain:** sub with `cmd_a_acc`=1, `acc`=44, B=44 → `res_data`=0, `res_zero`=1, `res_carry` per ALU borrow=0. Then sub A=`acc` (0), B=1 → `res_data`=255 with borrow flag set.
- **Carry masking and shifts:** after a carry=1 add, issue op 111 with A=0x81 → `res_data`=0x02, `res_carry`=0. Then op 101 with A=16, B=17 → `res_data`=0x10.
- **Back-pressure:** hold `res_ready`=0 for 10 cycles → `res_valid` stays 1, data stable, `cmd_ready`=0. A new `cmd_valid` is not accepted until one cycle after the `res_ready` handshake, and `op_count` increments once.
- **Reset mid-op:** assert `rst` in EXEC → `res_valid`=0, `acc`=0, `op_count` unchanged at 0, `cmd_ready`=1 immediately.
- **Counter wrap:** with CNT_W=4, complete 17 ops → `op_count`=1.
